wb_arbiter: RTL and testbench

Writeback stage directly upstream of the register file. Accepts completed results from two producers, the ALU and the load/store unit, each over a valid/ready handshake. Buffers each source in its own small FIFO and arbitrates round-robin. Drives the register file's single write port (write_reg_addr, data_in, write_ena) with at most one write per cycle.

---
 rtl/simplerv_pkg.sv | 10 +
 rtl/wb_fifo.sv | 57 +++++
 rtl/wb_arbiter.sv | 96 +++++++++
 tb/tb_wb_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/simplerv_pkg.sv
// Shared widths and source encoding for the writeback path.
package simplerv_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;
endpackage

// File: rtl/wb_fifo.sv
// Small per-source result queue; head is visible combinationally so the
// arbiter can decide and pop in the same cycle.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // A full queue refuses pushes even if it pops this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: queues ALU and LSU results and drives the register
// file write port round-robin, one write per cycle.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = simplerv_pkg::XLEN,
  parameter int AW    = simplerv_pkg::REG_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            write_ena,
  output logic [AW-1:0]   write_reg_addr,
  output logic [XLEN-1:0] data_in,
  output logic            idle
);
  import simplerv_pkg::*;

  localparam int EW = AW + XLEN;
  localparam int CW = $clog2(DEPTH + 1);

  logic [EW-1:0]   alu_dout, lsu_dout;
  logic            alu_empty, lsu_empty;
  logic            alu_full, lsu_full;
  logic [CW-1:0]   alu_count, lsu_count;
  logic [AW-1:0]   alu_head_rd, lsu_head_rd;
  logic [XLEN-1:0] alu_head_data, lsu_head_data;
  logic            grant_alu, grant_lsu;
  src_e            last_grant_reg;

  assign alu_ready = !alu_full;
  assign lsu_ready = !lsu_full;

  wb_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (alu_valid && alu_ready),
    .din   ({alu_rd, alu_data}),
    .pop   (grant_alu),
    .dout  (alu_dout),
    .empty (alu_empty),
    .full  (alu_full),
    .count (alu_count)
  );

  wb_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_lsu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (lsu_valid && lsu_ready),
    .din   ({lsu_rd, lsu_data}),
    .pop   (grant_lsu),
    .dout  (lsu_dout),
    .empty (lsu_empty),
    .full  (lsu_full),
    .count (lsu_count)
  );

  assign {alu_head_rd, alu_head_data} = alu_dout;
  assign {lsu_head_rd, lsu_head_data} = lsu_dout;

  // Under contention the source that did not win last time goes first.
  always_comb begin
    grant_alu = !alu_empty && (lsu_empty || (last_grant_reg == SRC_LSU));
    grant_lsu = !lsu_empty && !grant_alu;
  end

  // Entries for x0 are consumed as a grant but never raise write_ena.
  always_ff @(posedge clk) begin
    if (!rst) begin
      write_ena      <= 1'b0;
      write_reg_addr <= '0;
      data_in        <= '0;
      last_grant_reg <= SRC_LSU;
    end else if (grant_alu) begin
      write_ena      <= (alu_head_rd != '0);
      write_reg_addr <= alu_head_rd;
      data_in        <= alu_head_data;
      last_grant_reg <= SRC_ALU;
    end else if (grant_lsu) begin
      write_ena      <= (lsu_head_rd != '0);
      write_reg_addr <= lsu_head_rd;
      data_in        <= lsu_head_data;
      last_grant_reg <= SRC_LSU;
    end else begin
      write_ena <= 1'b0;
    end
  end

  assign idle = (alu_count == '0) && (lsu_count == '0) && !write_ena;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, latency, round-robin, backpressure,
// x0 drop and pointer wrap, with hand-computed expected write sequences.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd;
  logic [31:0] alu_data, lsu_data;
  logic        write_ena;
  logic [4:0]  write_reg_addr;
  logic [31:0] data_in;
  logic        idle;

  int compared   = 0;
  int mismatched = 0;

  wb_arbiter #(.DEPTH(2), .XLEN(32), .AW(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .lsu_valid      (lsu_valid),
    .lsu_ready      (lsu_ready),
    .lsu_rd         (lsu_rd),
    .lsu_data       (lsu_data),
    .write_ena      (write_ena),
    .write_reg_addr (write_reg_addr),
    .data_in        (data_in),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-14s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_we"}, 32'(write_ena), 32'd1);
    chk({tag, "_addr"}, 32'(write_reg_addr), 32'(rd));
    chk({tag, "_data"}, data_in, data);
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;

    // Reset state
    tick(); tick();
    chk("rst_we", 32'(write_ena), 32'd0);
    chk("rst_addr", 32'(write_reg_addr), 32'd0);
    chk("rst_data", data_in, 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_alu_rdy", 32'(alu_ready), 32'd1);
    chk("rst_lsu_rdy", 32'(lsu_ready), 32'd1);
    rst = 1'b1;
    tick();
    chk("post_rst_we", 32'(write_ena), 32'd0);

    // Contention after reset (last grant = LSU): expect rd 2,4,3,5
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h102;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h104;
    tick();
    chk("rr_e1_we", 32'(write_ena), 32'd0);
    alu_rd = 5'd3; alu_data = 32'h103;
    lsu_rd = 5'd5; lsu_data = 32'h105;
    tick();
    chk_wr("rr_w1", 5'd2, 32'h102);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tick();
    chk_wr("rr_w2", 5'd4, 32'h104);
    tick();
    chk_wr("rr_w3", 5'd3, 32'h103);
    tick();
    chk_wr("rr_w4", 5'd5, 32'h105);
    tick();
    chk("rr_done_we", 32'(write_ena), 32'd0);
    chk("rr_done_idle", 32'(idle), 32'd1);

    // Single ALU write: latency of two edges, one cycle of write_ena
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h114beef;
    tick();
    alu_valid = 1'b0;
    chk("one_n_we", 32'(write_ena), 32'd0);
    chk("one_n_idle", 32'(idle), 32'd0);
    tick();
    chk_wr("one_w", 5'd1, 32'h114beef);
    tick();
    chk("one_after_we", 32'(write_ena), 32'd0);
    chk("one_hold_addr", 32'(write_reg_addr), 32'd1);
    chk("one_hold_data", data_in, 32'h114beef);
    chk("one_idle", 32'(idle), 32'd1);

    // Backpressure (last grant = ALU): ALU 10,11,12 vs LSU 20,21,22
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'ha0a00001;
    lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h50500001;
    tick();
    chk("bp_e1_ardy", 32'(alu_ready), 32'd1);
    chk("bp_e1_we", 32'(write_ena), 32'd0);
    alu_rd = 5'd11; alu_data = 32'ha0a00002;
    lsu_rd = 5'd21; lsu_data = 32'h50500002;
    tick();
    chk("bp_full_ardy", 32'(alu_ready), 32'd0);
    chk_wr("bp_w1", 5'd20, 32'h50500001);
    alu_rd = 5'd12; alu_data = 32'ha0a00003;
    lsu_rd = 5'd22; lsu_data = 32'h50500003;
    tick();
    chk_wr("bp_w2", 5'd10, 32'ha0a00001);
    chk("bp_pop_ardy", 32'(alu_ready), 32'd1);
    chk("bp_lsu_full", 32'(lsu_ready), 32'd0);
    lsu_valid = 1'b0;
    tick();
    alu_valid = 1'b0;
    chk_wr("bp_w3", 5'd21, 32'h50500002);
    chk("bp_refull", 32'(alu_ready), 32'd0);
    tick();
    chk_wr("bp_w4", 5'd11, 32'ha0a00002);
    tick();
    chk_wr("bp_w5", 5'd22, 32'h50500003);
    tick();
    chk_wr("bp_w6", 5'd12, 32'ha0a00003);
    tick();
    chk("bp_done_we", 32'(write_ena), 32'd0);
    chk("bp_done_idle", 32'(idle), 32'd1);

    // Reset mid-stream with ALU queue full (last grant = ALU)
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h7777;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h9999;
    tick();
    chk("mr_e1_we", 32'(write_ena), 32'd0);
    alu_rd = 5'd8; alu_data = 32'h8888;
    lsu_valid = 1'b0;
    tick();
    chk_wr("mr_lsu", 5'd9, 32'h9999);
    chk("mr_full", 32'(alu_ready), 32'd0);
    alu_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr_we", 32'(write_ena), 32'd0);
    chk("mr_addr", 32'(write_reg_addr), 32'd0);
    chk("mr_data", data_in, 32'd0);
    chk("mr_idle", 32'(idle), 32'd1);
    chk("mr_ardy", 32'(alu_ready), 32'd1);
    tick();
    chk("mr_after1_we", 32'(write_ena), 32'd0);
    chk("mr_after1_idle", 32'(idle), 32'd1);
    tick();
    chk("mr_after2_we", 32'(write_ena), 32'd0);

    // x0 drop: entry consumed silently, next LSU entry follows
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1111111;
    tick();
    chk("x0_e1_we", 32'(write_ena), 32'd0);
    lsu_rd = 5'd6; lsu_data = 32'h66;
    tick();
    lsu_valid = 1'b0;
    chk("x0_drop_we", 32'(write_ena), 32'd0);
    chk("x0_idle", 32'(idle), 32'd0);
    tick();
    chk_wr("x0_next", 5'd6, 32'h66);
    tick();
    chk("x0_done_we", 32'(write_ena), 32'd0);
    chk("x0_done_idle", 32'(idle), 32'd1);

    // Wrap-around: 7 back-to-back LSU pushes
    for (int i = 1; i <= 7; i++) begin
      lsu_valid = 1'b1;
      lsu_rd    = 5'(i);
      lsu_data  = 32'h1000 * 32'(i);
      tick();
      if (i > 1) begin
        chk_wr("wrap", 5'(i - 1), 32'h1000 * 32'(i - 1));
      end
    end
    lsu_valid = 1'b0;
    tick();
    chk_wr("wrap_last", 5'd7, 32'h7000);
    tick();
    chk("wrap_done_we", 32'(write_ena), 32'd0);
    chk("wrap_done_idle", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
